imem_loader: RTL and testbench

Byte-stream program loader that writes 16-bit instructions into the CPU's instruction memory, which the CPU reads by PC byte address. It accepts a length-prefixed big-endian byte stream over a valid/ready handshake and packs byte pairs into instruction words. It issues one write per word at consecutive even byte addresses and holds the CPU stalled until loading completes.

---
 rtl/loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and widths for the instruction-memory loader
package loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 16;
  localparam int WORD_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [WORD_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  we,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output we,
    output waddr,
    output wdata
  );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed big-endian byte stream to 16-bit instruction writes
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                MAX_WORDS = 32768
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [WORD_W:0]   MAX_N = MAX_WORDS[WORD_W:0];
  localparam logic [WORD_W-1:0] STEP  = WORD_W'(WORD_BYTES);

  state_t            state;
  state_t            state_d;
  logic              rx_en;
  logic              xfer;
  logic [BYTE_W-1:0] len_hi_q;
  logic [BYTE_W-1:0] hi_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] remaining_q;
  logic [WORD_W-1:0] waddr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] len_n;
  logic              len_zero;
  logic              len_over;

  // Every output is a decode of the state register, so in_ready never depends on in_valid.
  assign rx_en        = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA_HI) || (state == DATA_LO);
  assign xfer         = rx_en & bus.in_valid;
  assign bus.in_ready = rx_en;
  assign bus.we       = (state == WRITE);
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign cpu_hold     = (state != IDLE) && (state != DONE);
  assign done         = (state == DONE);
  assign err          = (state == ERR);

  assign len_n    = {len_hi_q, bus.in_data};
  assign len_zero = (len_n == '0);
  assign len_over = ({1'b0, len_n} > MAX_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = LEN_HI;
      LEN_HI:  if (xfer)  state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_zero)      state_d = DONE;
          else if (len_over) state_d = ERR;
          else               state_d = DATA_HI;
        end
      end
      DATA_HI: if (xfer)  state_d = DATA_LO;
      DATA_LO: if (xfer)  state_d = WRITE;
      WRITE:   state_d = (remaining_q == WORD_W'(1)) ? DONE : DATA_HI;
      DONE:    if (start) state_d = LEN_HI;
      ERR:     if (start) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end

  // waddr/wdata are captured separately from the running address so they hold after WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q    <= '0;
      hi_q        <= '0;
      addr_q      <= BASE_ADDR;
      remaining_q <= '0;
      waddr_q     <= BASE_ADDR;
      wdata_q     <= '0;
    end else begin
      unique case (state)
        LEN_HI: begin
          if (xfer) len_hi_q <= bus.in_data;
        end
        LEN_LO: begin
          if (xfer) begin
            addr_q      <= BASE_ADDR;
            remaining_q <= len_n;
          end
        end
        DATA_HI: begin
          if (xfer) hi_q <= bus.in_data;
        end
        DATA_LO: begin
          if (xfer) begin
            wdata_q <= {hi_q, bus.in_data};
            waddr_q <= addr_q;
          end
        end
        WRITE: begin
          addr_q      <= addr_q + STEP;
          remaining_q <= remaining_q - WORD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and random loads on two instances (base 0x0000 and 0xFFFE)
module tb_imem_loader;
  import loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       hold0, hold1, done0, done1, err0, err1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader_if bus0 ();
  imem_loader_if bus1 ();

  assign bus0.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;

  imem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(32768)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(bus0),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  imem_loader #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(32768)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  logic        rdy_w[2], we_w[2], hold_w[2], done_w[2], err_w[2];
  logic [15:0] addr_w[2], data_w[2];
  assign rdy_w[0]  = bus0.in_ready;  assign rdy_w[1]  = bus1.in_ready;
  assign we_w[0]   = bus0.we;        assign we_w[1]   = bus1.we;
  assign addr_w[0] = bus0.waddr;     assign addr_w[1] = bus1.waddr;
  assign data_w[0] = bus0.wdata;     assign data_w[1] = bus1.wdata;
  assign hold_w[0] = hold0;          assign hold_w[1] = hold1;
  assign done_w[0] = done0;          assign done_w[1] = done1;
  assign err_w[0]  = err0;           assign err_w[1]  = err1;

  // Write log and done-rise log per instance; scenarios look only at entries past their snapshot.
  logic [31:0] wq[2][$];
  int          wc[2][$];
  int          dr[2][$];
  logic        dh[2][$];
  logic        pdone[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && we_w[i]) begin
        wq[i].push_back({addr_w[i], data_w[i]});
        wc[i].push_back(cyc);
      end
      if (!rst && done_w[i] && !pdone[i]) begin
        dr[i].push_back(cyc);
        dh[i].push_back(hold_w[i]);
      end
      pdone[i] = done_w[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] base_of(input int i);
    return (i == 0) ? 16'h0000 : 16'hFFFE;
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ready%0d", tag, i), 32'(rdy_w[i]), 0);
      chk($sformatf("%s_we%0d", tag, i), 32'(we_w[i]), 0);
      chk($sformatf("%s_hold%0d", tag, i), 32'(hold_w[i]), 0);
      chk($sformatf("%s_done%0d", tag, i), 32'(done_w[i]), 0);
      chk($sformatf("%s_err%0d", tag, i), 32'(err_w[i]), 0);
      chk($sformatf("%s_waddr%0d", tag, i), 32'(addr_w[i]), 32'(base_of(i)));
      chk($sformatf("%s_wdata%0d", tag, i), 32'(data_w[i]), 0);
    end
  endtask

  task automatic snap(output int ws[2], output int ds[2]);
    for (int i = 0; i < 2; i++) begin
      ws[i] = wq[i].size();
      ds[i] = dr[i].size();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      in_valid = 1'b0;
      repeat (2) begin
        in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!rdy_w[0] && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (t >= 20) chk("ready_timeout", 32'(t), 0);
    @(posedge clk); #1;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[k]) send_byte(s[k], gap);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic start_ok(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_start_ready%0d", tag, i), 32'(rdy_w[i]), 1);
      chk($sformatf("%s_start_hold%0d", tag, i), 32'(hold_w[i]), 1);
    end
  endtask

  // Reference: word k of a stream goes to base + 2k (mod 2^16) as {byte 2+2k, byte 3+2k}.
  task automatic check_writes(input string tag, input logic [7:0] s[$], input int ws[2],
                              input int ds[2], input bit contiguous);
    int n;
    logic [15:0] a;
    n = {s[0], s[1]};
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_count%0d", tag, i), 32'(wq[i].size() - ws[i]), 32'(n));
      for (int k = 0; k < n; k++) begin
        a = base_of(i) + 16'(2 * k);
        if (wq[i].size() > ws[i] + k)
          chk($sformatf("%s_w%0d_%0d", tag, k, i), wq[i][ws[i] + k], {a, s[2 + 2*k], s[3 + 2*k]});
        else
          chk($sformatf("%s_missing%0d_%0d", tag, k, i), 32'(wq[i].size()), 32'(ws[i] + k + 1));
      end
      chk($sformatf("%s_done_rises%0d", tag, i), 32'(dr[i].size() - ds[i]), 1);
      if (n > 0 && wq[i].size() >= ws[i] + n && dr[i].size() > ds[i]) begin
        chk($sformatf("%s_done_lat%0d", tag, i), 32'(dr[i][ds[i]]), 32'(wc[i][ws[i] + n - 1] + 1));
        chk($sformatf("%s_hold_fall%0d", tag, i), 32'(dh[i][ds[i]]), 0);
        if (contiguous)
          chk($sformatf("%s_rate%0d", tag, i),
              32'(wc[i][ws[i] + n - 1] - wc[i][ws[i]]), 32'(3 * (n - 1)));
      end
    end
  endtask

  task automatic run_load(input string tag, input logic [7:0] s[$], input bit gap);
    int ws[2], ds[2];
    snap(ws, ds);
    pulse_start();
    start_ok(tag);
    send_stream(s, gap);
    repeat (5) @(posedge clk);
    #1;
    check_writes(tag, s, ws, ds, !gap);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] tail[$];
    int ws[2], ds[2];
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    s = {8'h00, 8'h03, 8'h81, 8'h02, 8'h82, 8'h01, 8'h03, 8'h21};
    run_load("s1", s, 1'b0);

    snap(ws, ds);
    pulse_start();
    send_stream({8'h00, 8'h00}, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("zero_done%0d", i), 32'(done_w[i]), 1);
      chk($sformatf("zero_hold%0d", i), 32'(hold_w[i]), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("zero_count%0d", i), 32'(wq[i].size() - ws[i]), 0);

    snap(ws, ds);
    pulse_start();
    send_stream({8'h80, 8'h01}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("over_err%0d", i), 32'(err_w[i]), 1);
      chk($sformatf("over_hold%0d", i), 32'(hold_w[i]), 1);
      chk($sformatf("over_done%0d", i), 32'(done_w[i]), 0);
      chk($sformatf("over_count%0d", i), 32'(wq[i].size() - ws[i]), 0);
    end
    run_load("after_err", {8'h00, 8'h01, 8'hAB, 8'hCD}, 1'b0);
    for (int i = 0; i < 2; i++)
      chk($sformatf("after_err_clr%0d", i), 32'(err_w[i]), 0);

    run_load("gapped", s, 1'b1);

    snap(ws, ds);
    pulse_start();
    send_stream({8'h00, 8'h02, 8'h12, 8'h34, 8'h56}, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_count%0d", i), 32'(wq[i].size() - ws[i]), 1);
      if (wq[i].size() > ws[i])
        chk($sformatf("midrst_w%0d", i), wq[i][ws[i]], {base_of(i), 16'h1234});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_load("restart", {8'h00, 8'h02, 8'h5A, 8'hA5, 8'hC3, 8'h3C}, 1'b0);

    s    = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    tail = {8'h11, 8'h22, 8'h33, 8'h44};
    snap(ws, ds);
    pulse_start();
    send_stream({8'h00, 8'h02}, 1'b0);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ign_ready%0d", i), 32'(rdy_w[i]), 1);
      chk($sformatf("ign_hold%0d", i), 32'(hold_w[i]), 1);
      chk($sformatf("ign_done%0d", i), 32'(done_w[i]), 0);
    end
    send_stream(tail, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_writes("ignore_start", s, ws, ds, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      s = {8'(n >> 8), 8'(n)};
      for (int k = 0; k < 2 * n; k++) s.push_back(8'($urandom));
      run_load($sformatf("rand%0d", r), s, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
